instr_fetch_unit: RTL and testbench

- Upstream feeder for the datapath controller FSM: fetches 16-bit instructions from instruction memory, holds them in the instruction register (IR), and decodes IR fields.
- Starts the controller with a one-cycle `s` pulse, then waits for the controller to return to its wait state (`w` high) before fetching the next instruction.
- Also muxes register numbers for the register file from the controller's one-hot `nsel`.

---
 rtl/instr_fetch_unit.sv | 80 ++++++++
 tb/tb_instr_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 16-bit instructions into IR, starts the controller (s/w handshake), decodes IR fields and muxes register numbers by nsel
module instr_fetch_unit #(
  parameter int PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic                mem_req,
  input  logic                mem_ready,
  input  logic [15:0]         mem_rdata,
  input  logic                w,
  output logic                s,
  input  logic [2:0]          nsel,
  output logic [2:0]          opcode,
  output logic [1:0]          op,
  output logic [1:0]          shift,
  output logic [15:0]         sximm5,
  output logic [15:0]         sximm8,
  output logic [2:0]          readnum,
  output logic [2:0]          writenum,
  output logic [PC_WIDTH-1:0] pc,
  output logic [15:0]         retired,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, FETCH, START, BUSY} state_t;
  state_t r_state, w_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [15:0] r_ir, r_retired;
  logic r_seen_low, w_done;
  assign w_done = r_state == BUSY && r_seen_low && w;
  always_comb begin
    w_next = r_state;
    s = 1'b0;
    mem_req = 1'b0;
    busy = r_state != IDLE;
    case (r_state)
      IDLE: w_next = run && w ? FETCH : IDLE;
      FETCH: begin
        mem_req = 1'b1;
        w_next = mem_ready ? START : FETCH;
      end
      START: begin
        s = 1'b1;
        w_next = BUSY;
      end
      BUSY: w_next = w_done ? (run ? FETCH : IDLE) : BUSY;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
      r_ir <= '0;
      r_retired <= '0;
      r_seen_low <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && mem_ready) begin
        r_ir <= mem_rdata;
        r_pc <= r_pc + 1'b1;
      end
      if (r_state == START) r_seen_low <= 1'b0;
      if (r_state == BUSY && !w) r_seen_low <= 1'b1;
      if (w_done) r_retired <= r_retired + 16'd1;
    end
  end
  assign mem_addr = r_pc;
  assign pc = r_pc;
  assign retired = r_retired;
  assign opcode = r_ir[15:13];
  assign op = r_ir[12:11];
  assign shift = r_ir[4:3];
  assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};
  assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
  assign readnum = nsel == 3'b001 ? r_ir[10:8] : nsel == 3'b010 ? r_ir[7:5] : nsel == 3'b100 ? r_ir[2:0] : 3'b000;
  assign writenum = readnum;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized scoreboard bench with memory and controller models for instr_fetch_unit
module tb_instr_fetch_unit;
  localparam int PW = 2;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0, mem_ready = 1'b0, w = 1'b1;
  logic [15:0] mem_rdata = '0;
  logic [2:0] nsel = '0;
  logic [PW-1:0] mem_addr, pc;
  logic mem_req, s, busy;
  logic [2:0] opcode, readnum, writenum;
  logic [1:0] op, shift;
  logic [15:0] sximm5, sximm8, retired;
  instr_fetch_unit #(.PC_WIDTH(PW), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .w(w), .s(s), .nsel(nsel),
    .opcode(opcode), .op(op), .shift(shift), .sximm5(sximm5), .sximm8(sximm8),
    .readnum(readnum), .writenum(writenum), .pc(pc), .retired(retired), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {logic [15:0] word; int pc;} exp_t;
  exp_t sb[$];
  logic [15:0] dir_q[$];
  int lat_q[$];
  int n_cmp = 0, n_bad = 0;
  int m_pc = 0, m_s = 0, lat = 0, c_hi = 0, c_lo = 0, cyc = 0;
  logic [15:0] m_ir = '0, acc_word = '0;
  bit acc_prev = 0, rst_prev = 0, in_fetch = 0, act = 0, rnd_lat = 0;
  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    end
  endtask
  function automatic logic [2:0] reg_of(input logic [15:0] ir, input logic [2:0] n);
    case (n)
      3'b001: return ir[10:8];
      3'b010: return ir[7:5];
      3'b100: return ir[2:0];
      default: return 3'b000;
    endcase
  endfunction
  function automatic logic [15:0] sext(input int v, input int bits);
    int x;
    x = v % (1 << bits);
    if (x >= (1 << (bits - 1))) x -= (1 << bits);
    return 16'(x);
  endfunction
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst_prev) begin
      m_pc = 0; m_ir = '0; m_s = 0; acc_prev = 0; in_fetch = 0; act = 0; w = 1'b1;
      sb.delete();
    end else if (acc_prev) begin
      m_ir = acc_word;
      m_pc = (m_pc + 1) % (1 << PW);
    end
    chk("s_after_fetch", s, acc_prev);
    chk("s_req_exclusive", s & mem_req, 0);
    chk("mem_addr", mem_addr, m_pc);
    chk("pc", pc, m_pc);
    nsel = 3'(cyc % 8);
    #1;
    chk("readnum", readnum, reg_of(m_ir, nsel));
    chk("writenum", writenum, reg_of(m_ir, nsel));
    acc_prev = 0;
    if (reset) begin
      mem_ready = 1'b0;
      in_fetch = 0;
    end else if (mem_req) begin
      if (!in_fetch) begin
        in_fetch = 1;
        lat = lat_q.size() > 0 ? lat_q.pop_front() : (rnd_lat ? int'($urandom_range(0, 3)) : 0);
      end
      if (lat > 0) begin
        lat--;
        mem_ready = 1'b0;
        mem_rdata = 16'($urandom);
      end else begin
        acc_word = dir_q.size() > 0 ? dir_q.pop_front() : 16'($urandom);
        mem_ready = 1'b1;
        mem_rdata = acc_word;
        acc_prev = 1;
        in_fetch = 0;
        sb.push_back('{acc_word, (m_pc + 1) % (1 << PW)});
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
    end
    if (s) begin
      c_hi = $urandom_range(0, 2);
      c_lo = $urandom_range(1, 4);
      act = 1;
    end else if (act) begin
      if (c_hi > 0) begin w = 1'b1; c_hi--; end
      else if (c_lo > 0) begin w = 1'b0; c_lo--; end
      else begin w = 1'b1; act = 0; end
    end
    rst_prev = reset;
  end
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (s === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got start pulse, expected no pending instruction");
      end else begin
        e = sb.pop_front();
        chk("opcode", opcode, e.word[15:13]);
        chk("op", op, e.word[12:11]);
        chk("shift", shift, e.word[4:3]);
        chk("sximm5", sximm5, sext(int'(e.word[4:0]), 5));
        chk("sximm8", sximm8, sext(int'(e.word[7:0]), 8));
        chk("pc_at_start", pc, e.pc);
        chk("retired_at_start", retired, m_s);
        m_s++;
      end
    end
  end
  task automatic wait_s(input int n, input int budget);
    int k = 0;
    while (m_s < n && k < budget) begin @(posedge clk); #2; k++; end
    chk("wait_start_count", m_s >= n, 1);
  endtask
  task automatic wait_state(input int which, input int budget);
    int k = 0;
    bit hit = 0;
    while (!hit && k < budget) begin
      @(posedge clk); #2; k++;
      hit = which == 0 ? mem_req : which == 1 ? (busy && !s && !mem_req) : !busy;
    end
    chk("wait_state", hit, 1);
  endtask
  task automatic pulse_reset_and_check(input string nm);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_pc"}, pc, 0);
    chk({nm, "_s"}, s, 0);
    chk({nm, "_mem_req"}, mem_req, 0);
    chk({nm, "_retired"}, retired, 0);
    @(negedge clk); #3;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    chk("rst_pc", pc, 0);
    chk("rst_s", s, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_retired", retired, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_sximm8", sximm8, 0);
    repeat (10) begin
      @(posedge clk); #2;
      chk("idle_no_req", mem_req, 0);
      chk("idle_not_busy", busy, 0);
    end
    dir_q = '{16'hD007, 16'hA140, 16'h12F8};
    lat_q = '{0, 0, 3};
    run = 1'b1;
    wait_s(3, 200);
    rnd_lat = 1;
    wait_s(30, 3000);
    lat_q.push_back(6);
    wait_state(0, 200);
    pulse_reset_and_check("rst_fetch");
    wait_s(2, 300);
    wait_state(1, 200);
    pulse_reset_and_check("rst_busy");
    lat_q.delete();
    wait_s(5, 500);
    run = 1'b0;
    wait_state(2, 200);
    chk("halt_retired", retired, 5);
    chk("halt_pc_wrapped", pc, 1);
    repeat (10) begin
      @(posedge clk); #2;
      chk("halt_no_req", mem_req, 0);
      chk("halt_idle", busy, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
